// File: rtl/r4_pkg.sv
// Shared types and constants for the sequential radix-4 transform engine.
package r4_pkg;

    localparam int R4_W = 4;

    typedef enum logic [1:0] {
        IDLE,
        COMP,
        HOLD
    } state_t;

    typedef logic [1:0] bin_t;

endpackage

// File: rtl/r4_bin_calc.sv
// Combinational radix-4 single-bin evaluator (forward or inverse), modulo 2^W.
module r4_bin_calc
    import r4_pkg::*;
#(
    parameter int W = R4_W
) (
    input  logic [W-1:0] xr0,
    input  logic [W-1:0] xi0,
    input  logic [W-1:0] xr1,
    input  logic [W-1:0] xi1,
    input  logic [W-1:0] xr2,
    input  logic [W-1:0] xi2,
    input  logic [W-1:0] xr3,
    input  logic [W-1:0] xi3,
    input  bin_t         k,
    input  logic         inv,
    output logic [W-1:0] re,
    output logic [W-1:0] im
);

    // Inverse swaps the odd bins, so flip k[1] for odd k when inv is set.
    bin_t k_eff;
    assign k_eff = {k[1] ^ (inv & k[0]), k[0]};

    always_comb begin
        re = '0;
        im = '0;
        case (k_eff)
            2'd0: begin
                re = xr0 + xr1 + xr2 + xr3;
                im = xi0 + xi1 + xi2 + xi3;
            end
            2'd1: begin
                re = xr0 + xi1 - xr2 - xi3;
                im = xi0 - xr1 - xi2 + xr3;
            end
            2'd2: begin
                re = xr0 - xr1 + xr2 - xr3;
                im = xi0 - xi1 + xi2 - xi3;
            end
            default: begin
                re = xr0 - xi1 - xr2 + xi3;
                im = xi0 + xr1 - xi2 - xr3;
            end
        endcase
    end

endmodule

// File: rtl/r4_idft_seq.sv
// Sequential radix-4 DFT/IDFT engine: loads one 4-sample block, streams four bins.
module r4_idft_seq
    import r4_pkg::*;
#(
    parameter int W = R4_W
) (
    input  logic         wb_clk_i,
    input  logic         wb_rst_i,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         inv,
    input  logic [W-1:0] xr0,
    input  logic [W-1:0] xi0,
    input  logic [W-1:0] xr1,
    input  logic [W-1:0] xi1,
    input  logic [W-1:0] xr2,
    input  logic [W-1:0] xi2,
    input  logic [W-1:0] xr3,
    input  logic [W-1:0] xi3,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_re,
    output logic [W-1:0] out_im,
    output logic [1:0]   out_bin,
    output logic         out_last,
    output logic         busy
);

    state_t              state, state_nx;
    bin_t                k;
    logic                inv_q;
    logic [3:0][W-1:0]   xr_q, xi_q;
    logic [W-1:0]        bin_re, bin_im;

    r4_bin_calc #(.W(W)) u_calc (
        .xr0 (xr_q[0]),
        .xi0 (xi_q[0]),
        .xr1 (xr_q[1]),
        .xi1 (xi_q[1]),
        .xr2 (xr_q[2]),
        .xi2 (xi_q[2]),
        .xr3 (xr_q[3]),
        .xi3 (xi_q[3]),
        .k   (k),
        .inv (inv_q),
        .re  (bin_re),
        .im  (bin_im)
    );

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) state <= IDLE;
        else          state <= state_nx;
    end

    always_comb begin
        state_nx  = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = (state != IDLE);
        case (state)
            IDLE: begin
                in_ready = !wb_rst_i;
                if (in_valid) state_nx = COMP;
            end
            COMP: state_nx = HOLD;
            HOLD: begin
                out_valid = 1'b1;
                if (out_ready) state_nx = (k == 2'd3) ? IDLE : COMP;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            k        <= '0;
            inv_q    <= 1'b0;
            xr_q     <= '0;
            xi_q     <= '0;
            out_re   <= '0;
            out_im   <= '0;
            out_bin  <= '0;
            out_last <= 1'b0;
        end else begin
            if (state == IDLE && in_valid) begin
                k     <= '0;
                inv_q <= inv;
                xr_q  <= {xr3, xr2, xr1, xr0};
                xi_q  <= {xi3, xi2, xi1, xi0};
            end
            if (state == COMP) begin
                out_re   <= bin_re;
                out_im   <= bin_im;
                out_bin  <= k;
                out_last <= (k == 2'd3);
            end
            if (state == HOLD && out_ready && k != 2'd3) k <= k + 2'd1;
        end
    end

endmodule

// File: tb/tb_r4_idft_seq.sv
// Self-checking bench for r4_idft_seq: twiddle-based DFT model, scoreboard, directed and random blocks.
module tb_r4_idft_seq;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid, in_ready, inv;
    logic [3:0] xr0, xi0, xr1, xi1, xr2, xi2, xr3, xi3;
    logic       out_valid, out_ready, out_last, busy;
    logic [3:0] out_re, out_im;
    logic [1:0] out_bin;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [3:0] re;
        logic [3:0] im;
        logic [1:0] bin;
        logic       last;
    } exp_t;

    exp_t q[$];

    r4_idft_seq #(.W(4)) dut (
        .wb_clk_i (clk),
        .wb_rst_i (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .inv      (inv),
        .xr0 (xr0), .xi0 (xi0), .xr1 (xr1), .xi1 (xi1),
        .xr2 (xr2), .xi2 (xi2), .xr3 (xr3), .xi3 (xi3),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_re   (out_re),
        .out_im   (out_im),
        .out_bin  (out_bin),
        .out_last (out_last),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // X[k] = sum_n x[n] * w^(n*k), w = -j forward, +j inverse; result packed {re,im}.
    function automatic logic [7:0] model(input logic [3:0] r0, i0, r1, i1, r2, i2, r3, i3,
                                         input int k, input logic iv);
        logic [3:0] r[4];
        logic [3:0] i[4];
        logic [3:0] sr, si, a, b, t;
        r[0] = r0; r[1] = r1; r[2] = r2; r[3] = r3;
        i[0] = i0; i[1] = i1; i[2] = i2; i[3] = i3;
        sr = 4'd0;
        si = 4'd0;
        for (int n = 0; n < 4; n++) begin
            a = r[n];
            b = i[n];
            for (int m = 0; m < (n * k) % 4; m++) begin
                t = a;
                if (!iv) begin a = b;  b = 4'd0 - t; end
                else     begin a = 4'd0 - b; b = t;  end
            end
            sr = sr + a;
            si = si + b;
        end
        return {sr, si};
    endfunction

    // Scoreboard / compare process, sampling on the falling edge.
    logic        prev_valid = 1'b0;
    logic        prev_hs = 1'b0;
    logic [10:0] prev_word = '0;
    always @(negedge clk) begin
        exp_t       e;
        logic [7:0] m;
        if (out_valid === 1'b1) begin
            if (q.size() == 0) begin
                chk("unexpected_output", 1, 0);
            end else begin
                e = q[0];
                chk("bin_re", int'(out_re), int'(e.re));
                chk("bin_im", int'(out_im), int'(e.im));
                chk("bin_idx", int'(out_bin), int'(e.bin));
                chk("bin_last", int'(out_last), int'(e.last));
            end
            chk("in_ready_while_valid", int'(in_ready), 0);
            if (prev_valid && !prev_hs)
                chk("hold_stable", int'({out_re, out_im, out_bin, out_last}), int'(prev_word));
        end
        if (rst) begin
            q.delete();
            prev_valid = 1'b0;
            prev_hs    = 1'b0;
        end else begin
            prev_valid = (out_valid === 1'b1);
            prev_hs    = (out_valid === 1'b1) && out_ready;
            prev_word  = {out_re, out_im, out_bin, out_last};
            if (prev_hs && q.size() > 0) void'(q.pop_front());
            if (in_valid && in_ready === 1'b1) begin
                for (int k = 0; k < 4; k++) begin
                    m      = model(xr0, xi0, xr1, xi1, xr2, xi2, xr3, xi3, k, inv);
                    e.re   = m[7:4];
                    e.im   = m[3:0];
                    e.bin  = 2'(k);
                    e.last = (k == 3);
                    q.push_back(e);
                end
            end
        end
    end

    task automatic set_data(input logic [3:0] r0, i0, r1, i1, r2, i2, r3, i3, input logic iv);
        xr0 = r0; xi0 = i0; xr1 = r1; xi1 = i1;
        xr2 = r2; xi2 = i2; xr3 = r3; xi3 = i3;
        inv = iv;
    endtask

    // Presents a block; returns after the accept edge with in_valid dropped.
    task automatic send(input logic [3:0] r0, i0, r1, i1, r2, i2, r3, i3, input logic iv);
        bit ok = 1'b0;
        @(posedge clk); #1;
        set_data(r0, i0, r1, i1, r2, i2, r3, i3, iv);
        in_valid = 1'b1;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (in_ready === 1'b1) begin ok = 1'b1; break; end
        end
        if (!ok) chk("send_timeout", 0, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        bit ok = 1'b0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (busy === 1'b0) begin ok = 1'b1; break; end
        end
        if (!ok) chk("idle_timeout", 0, 1);
    endtask

    task automatic wait_valid();
        bit ok = 1'b0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (out_valid === 1'b1) begin ok = 1'b1; break; end
        end
        if (!ok) chk("valid_timeout", 0, 1);
    endtask

    initial begin
        logic [7:0] m;
        logic [3:0] held_re, held_im;
        bit         hs;
        int         sent, cyc;

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        set_data(0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Model pinned against hand-computed bins
        m = model(0, 0, 1, 0, 0, 0, 0, 0, 1, 0); chk("model_fwd_k1", int'(m), 8'h0F);
        m = model(0, 0, 1, 0, 0, 0, 0, 0, 2, 0); chk("model_fwd_k2", int'(m), 8'hF0);
        m = model(0, 0, 1, 0, 0, 0, 0, 0, 3, 0); chk("model_fwd_k3", int'(m), 8'h01);
        m = model(0, 0, 1, 0, 0, 0, 0, 0, 1, 1); chk("model_inv_k1", int'(m), 8'h01);
        m = model(0, 0, 1, 0, 0, 0, 0, 0, 3, 1); chk("model_inv_k3", int'(m), 8'h0F);
        m = model(4, 0, 4, 0, 4, 0, 4, 0, 0, 0); chk("model_wrap_k0", int'(m), 8'h00);

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_in_ready", int'(in_ready), 0);
        chk("rst_out_re", int'(out_re), 0);
        chk("rst_out_bin", int'(out_bin), 0);
        chk("rst_out_last", int'(out_last), 0);
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("ready_after_rst", int'(in_ready), 1);

        // Impulse: bin0 lands two edges after the accept edge
        send(1, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("t1_no_valid", int'(out_valid), 0);
        chk("t1_busy", int'(busy), 1);
        @(negedge clk);
        chk("t2_valid", int'(out_valid), 1);
        chk("t2_bin0", int'(out_bin), 0);
        chk("t2_re", int'(out_re), 1);
        wait_idle();

        send(0, 0, 1, 0, 0, 0, 0, 0, 0); wait_idle();
        send(0, 0, 1, 0, 0, 0, 0, 0, 1); wait_idle();
        send(4, 0, 4, 0, 4, 0, 4, 0, 0); wait_idle();

        // Backpressure on bin1 with a stray in_valid pulse
        @(posedge clk); #1 out_ready = 1'b0;
        send(3, 7, 9, 2, 14, 5, 6, 11, 0);
        wait_valid();
        @(posedge clk); #1 out_ready = 1'b1;
        @(posedge clk); #1 out_ready = 1'b0;
        wait_valid();
        chk("bp_bin1", int'(out_bin), 1);
        held_re = out_re;
        held_im = out_im;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            if (c == 1) begin set_data(15, 15, 15, 15, 15, 15, 15, 15, 1); in_valid = 1'b1; end
            if (c == 3) in_valid = 1'b0;
            @(negedge clk);
            chk("bp_valid", int'(out_valid), 1);
            chk("bp_in_ready", int'(in_ready), 0);
            chk("bp_re_held", int'(out_re), int'(held_re));
            chk("bp_im_held", int'(out_im), int'(held_im));
        end
        @(posedge clk); #1 out_ready = 1'b1;
        wait_idle();
        @(negedge clk);
        chk("ready_after_last", int'(in_ready), 1);

        // Reset while holding bin2
        @(posedge clk); #1 out_ready = 1'b0;
        send(5, 1, 2, 8, 7, 3, 9, 4, 1);
        for (int c = 0; c < 3; c++) begin
            wait_valid();
            if (out_bin == 2'd2) break;
            @(posedge clk); #1 out_ready = 1'b1;
            @(posedge clk); #1 out_ready = 1'b0;
        end
        chk("abort_at_bin2", int'(out_bin), 2);
        @(posedge clk); #1 rst = 1'b1;
        @(negedge clk);
        chk("in_ready_in_rst", int'(in_ready), 0);
        @(negedge clk);
        chk("abort_valid", int'(out_valid), 0);
        chk("abort_busy", int'(busy), 0);
        chk("abort_re", int'(out_re), 0);
        chk("abort_im", int'(out_im), 0);
        @(posedge clk); #1 rst = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        chk("ready_after_abort", int'(in_ready), 1);
        send(3, 5, 0, 0, 0, 0, 0, 0, 0);
        wait_valid();
        chk("fresh_bin0_re", int'(out_re), 3);
        chk("fresh_bin0_im", int'(out_im), 5);
        wait_idle();

        // Randomized blocks with random backpressure
        sent = 0;
        cyc  = 0;
        while (sent < 40 && cyc < 20000) begin
            @(negedge clk);
            hs = in_valid && (in_ready === 1'b1);
            @(posedge clk); #1;
            cyc++;
            out_ready = ($urandom_range(0, 3) != 0);
            if (hs) begin in_valid = 1'b0; sent++; end
            if (!in_valid && sent < 40 && $urandom_range(0, 1) == 1) begin
                set_data(4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom),
                         4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom),
                         1'($urandom));
                in_valid = 1'b1;
            end
        end
        chk("random_blocks_sent", sent, 40);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        wait_idle();
        @(negedge clk);
        chk("queue_drained", q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
